// File: rtl/rsp_s2_prep_diff_ctrl_if.sv
// ============================================================================
// Module      : rsp_s2_prep_diff_ctrl_if
// Description : Scheduler / sample-RAM / datapath signal bundle for the
//               stage-2 preprocessing difference frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rsp_s2_prep_diff_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  i_start;
    logic                  i_bank;
    logic                  i_mode;
    logic                  i_dn_ready;
    logic                  i_err_clr;
    logic                  o_ram_rd_en;
    logic [ADDR_WIDTH-1:0] o_ram_rd_addr;
    logic                  o_x0_valid;
    logic                  o_x0_last;
    logic                  o_switch;
    logic                  o_busy;
    logic                  o_done;
    logic [15:0]           o_frame_cnt;
    logic                  o_err;

    modport master (
        output i_start, i_bank, i_mode, i_dn_ready, i_err_clr,
        input  o_ram_rd_en, o_ram_rd_addr, o_x0_valid, o_x0_last,
               o_switch, o_busy, o_done, o_frame_cnt, o_err
    );

    modport slave (
        input  i_start, i_bank, i_mode, i_dn_ready, i_err_clr,
        output o_ram_rd_en, o_ram_rd_addr, o_x0_valid, o_x0_last,
               o_switch, o_busy, o_done, o_frame_cnt, o_err
    );
endinterface

`default_nettype wire

// File: rtl/rsp_s2_prep_diff_ctrl.sv
// ============================================================================
// Module      : rsp_s2_prep_diff_ctrl
// Description : Frame sequencer: bursts one frame out of the ping-pong sample
//               RAM, aligns valid/last to read data, waits for the datapath to
//               drain, then pulses done. Optional sticky start-error flag is
//               enabled by defining RSP_S2_PREP_DIFF_CTRL_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsp_s2_prep_diff_ctrl #(
    parameter int DATA_NUM  = 1024,
    parameter int BURST_LEN = 8,
    parameter int RD_LAT    = 2,
    parameter int DIFF_LAT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    rsp_s2_prep_diff_ctrl_if.slave  bus
);

    localparam int NBEAT      = DATA_NUM / BURST_LEN;
    localparam int ADDR_WIDTH = $clog2(NBEAT) + 1;
    localparam int BEAT_W     = ADDR_WIDTH - 1;
    localparam int DRAIN_CYC  = RD_LAT + DIFF_LAT;
    localparam int DRAIN_W    = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  bank_q, bank_d;
    logic                  switch_q, switch_d;
    logic                  rd_en_q;
    logic                  last_rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic [15:0]           frame_cnt_q;
    logic [RD_LAT-1:0]     vld_sr_q;
    logic [RD_LAT-1:0]     last_sr_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        drain_d  = drain_q;
        bank_d   = bank_q;
        switch_d = switch_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start && bus.i_dn_ready) begin
                    bank_d   = bus.i_bank;
                    switch_d = bus.i_mode;
                    beat_d   = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_q == BEAT_W'(NBEAT - 1)) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            drain_q     <= '0;
            bank_q      <= 1'b0;
            switch_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            last_rd_q   <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            bank_q    <= bank_d;
            switch_q  <= switch_d;
            rd_en_q   <= (state_d == S_BURST);
            last_rd_q <= (state_d == S_BURST) && (beat_d == BEAT_W'(NBEAT - 1));
            addr_q    <= (state_d == S_BURST) ? {bank_d, beat_d} : '0;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            if (state_q == S_DONE) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            vld_sr_q[0]  <= rd_en_q;
            last_sr_q[0] <= last_rd_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr_q[i]  <= vld_sr_q[i-1];
                last_sr_q[i] <= last_sr_q[i-1];
            end
        end
    end

    assign bus.o_ram_rd_en   = rd_en_q;
    assign bus.o_ram_rd_addr = addr_q;
    assign bus.o_x0_valid    = vld_sr_q[RD_LAT-1];
    assign bus.o_x0_last     = last_sr_q[RD_LAT-1];
    assign bus.o_switch      = switch_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_frame_cnt   = frame_cnt_q;

`ifdef RSP_S2_PREP_DIFF_CTRL_ERR_EN
    logic w_err_set;
    logic err_q;

    // busy_q is low only in IDLE, so this covers both drop cases.
    assign w_err_set = bus.i_start && (busy_q || !bus.i_dn_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_err_set) begin
            err_q <= 1'b1;
        end else if (bus.i_err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/rsp_s2_prep_diff_ctrl.md
# rsp_s2_prep_diff_ctrl

Frame sequencer for the stage-2 preprocessing difference datapath. On a start request it reads one frame of `DATA_NUM` samples from the ping-pong sample RAM as back-to-back `BURST_LEN`-sample beats. It drives the datapath's valid/last/switch inputs aligned to RAM read data, then waits for the datapath pipeline to drain before reporting completion. It sits between the stage-2 scheduler (start/bank/mode) and the sample RAM read port plus difference datapath.

## Interface
Parameters:
- `DATA_NUM`, 1024: samples per frame; must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 8: samples per beat.
- `RD_LAT`, 2: sample-RAM read latency in cycles, ≥1.
- `DIFF_LAT`, 4: datapath input-valid to output-valid latency in cycles.
- Derived: `NBEAT = DATA_NUM/BURST_LEN` (must be ≥2); `ADDR_WIDTH = $clog2(NBEAT)+1`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `i_start`  in  1  frame request, single-cycle pulse.
- `i_bank`  in  1  RAM half to read; becomes the address MSB.
- `i_mode`  in  1  1 = first-order difference; 0 = two-sample difference.
- `i_dn_ready`  in  1  downstream able to absorb a whole frame.
- `o_ram_rd_en`  out  1  RAM read enable.
- `o_ram_rd_addr`  out  ADDR_WIDTH  `{bank, beat}` address.
- `o_x0_valid`  out  1  datapath input valid, aligned to RAM data.
- `o_x0_last`  out  1  marks the final beat of the frame.
- `o_switch`  out  1  datapath mode select.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle frame-complete pulse.
- `o_frame_cnt`  out  16  completed frames.
- `o_err`  out  1  sticky error; present only with the macro, otherwise tied 0.
- `i_err_clr`  in  1  clears `o_err`; present only with the macro.

## Operation
FSM states: IDLE → BURST → DRAIN → DONE → IDLE.
- **IDLE**: `i_start && i_dn_ready` accepts a frame.
  - Latch `i_bank` and `i_mode`. `o_switch` takes `i_mode` and holds it until the next accepted start, including through IDLE.
  - Clear the beat counter and go to BURST.
  - `i_start` with `i_dn_ready`=0 is dropped. It is not queued.
- **BURST**:
  - `o_ram_rd_en`=1 every cycle, with no gaps. The datapath shifts every clock, so a gap corrupts the carried boundary samples.
  - Address = `{bank, beat}`, beat counting 0..NBEAT-1.
  - After beat NBEAT-1, go to DRAIN.
- **DRAIN**: counts `RD_LAT+DIFF_LAT` cycles, then goes to DONE.
- **DONE**: one cycle.
  - `o_done`=1.
  - `o_frame_cnt` increments, wrapping 0xFFFF→0.
  - Return to IDLE.
- `o_x0_valid` is `o_ram_rd_en` delayed `RD_LAT` cycles through a shift register.
- `o_x0_last` is the read-enable-of-final-beat flag delayed `RD_LAT` cycles.
- `o_busy` is 1 in BURST, DRAIN and DONE.
- `i_start` outside IDLE is ignored. It is flagged only when the macro is enabled.
- `i_dn_ready` is sampled only at acceptance. Deassertion mid-frame has no effect.
- Reset at any point, including mid-frame:
  - State returns to IDLE and the valid/last delay lines are flushed.
  - All outputs go to 0: `o_ram_rd_en`, `o_ram_rd_addr`, `o_x0_valid`, `o_x0_last`, `o_switch`, `o_busy`, `o_done`, `o_frame_cnt`, `o_err`.

## Timing
Times below assume the start is accepted in cycle T.
- `o_busy` rises at T+1.
- `o_ram_rd_en`: T+1..T+NBEAT, addresses 0..NBEAT-1.
- `o_x0_valid`: T+1+RD_LAT..T+NBEAT+RD_LAT.
- `o_x0_last`: T+NBEAT+RD_LAT only.
- DRAIN: T+NBEAT+1..T+NBEAT+RD_LAT+DIFF_LAT.
- `o_done` and the count update: T+NBEAT+RD_LAT+DIFF_LAT+1. `o_frame_cnt` shows the new value the following cycle.
- `o_busy` falls at T+NBEAT+RD_LAT+DIFF_LAT+2.
- Earliest next acceptance is that same cycle. Minimum start-to-start period = NBEAT+RD_LAT+DIFF_LAT+2; with defaults this is 136 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `RSP_S2_PREP_DIFF_CTRL_ERR_EN` defined:
  - `o_err` is set in the cycle after any `i_start` arriving while `o_busy`=1, or while `i_dn_ready`=0 in IDLE.
  - `o_err` holds until `i_err_clr`.
  - If set and clear happen in the same cycle, set wins.
- Macro undefined:
  - `o_err` is constant 0 and `i_err_clr` is unused.
  - Dropped starts are silent.

## Test plan
All scenarios use default parameters: NBEAT=128, RD_LAT=2, DIFF_LAT=4.
- Reset then idle → all outputs 0 and `o_frame_cnt`=0 for 20 cycles.
- Start at T with bank=1, mode=1, ready=1 → `o_ram_rd_en` at T+1..T+128 with addresses 128..255. `o_x0_valid` at T+3..T+130, `o_x0_last` at T+130 only. `o_switch`=1 from T+1. `o_done` at T+135, `o_frame_cnt`=1.
- Second start with bank=0, mode=0 held until busy falls → accepted at T+136. Addresses 0..127, `o_switch` goes to 0, `o_frame_cnt`=2. Valid shows no gaps within either frame.
- Start with ready=0, then a start at T+50 during a frame → both ignored, frame timing unchanged. With the macro, `o_err`=1 persists until `i_err_clr`.
- `rst` asserted at T+60 mid-burst → next cycle all outputs 0 and state IDLE. A fresh start then behaves exactly as in the second scenario.
- Preload `o_frame_cnt` via 65535 frames (or force) and run one more → count wraps to 0.
